// File: rtl/off_chip_img_source.sv
// Deterministic raster-order pixel source answering an app's read_en requests
// with one registered pixel per accepted request, one cycle later.
module off_chip_img_source #(
  parameter int          WIDTH = 16,
  parameter int          IMG_W = 64,
  parameter int          IMG_H = 64,
  parameter logic [15:0] SEED  = 16'hACE1,
  localparam int         CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int         RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       pattern_sel,
  input  logic [WIDTH-1:0] cfg_const,
  input  logic             off_chip_img_img_update_0_read_en,
  output logic [WIDTH-1:0] off_chip_img_img_update_0_read,
  output logic             read_valid,
  output logic [CW-1:0]    col,
  output logic [RW-1:0]    row,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  // Handshake: the source is always ready, so every cycle with read_en=1 and
  // flush=0 is a transfer; read_valid marks the returned pixel one cycle later
  // and the data bus holds its last value whenever read_valid is low.

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  pat_e             pat;
  pat_e             pat_eff;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] pixel;
  logic             accept;
  logic             at_origin;
  logic             last_col;
  logic             last_row;

  assign accept    = off_chip_img_img_update_0_read_en && !flush;
  assign at_origin = (row == '0) && (col == '0);
  assign last_col  = (col == CW'(IMG_W - 1));
  assign last_row  = (row == RW'(IMG_H - 1));

  // The pattern register is only re-sampled at the start of a frame, and the
  // origin pixel already uses the freshly sampled selection.
  always_comb begin
    pat_eff = pat;
    if (at_origin) begin
      pat_eff = pat_e'(pattern_sel);
    end
    pixel = '0;
    case (pat_eff)
      PAT_RAMP:  pixel = WIDTH'(32'(row) * IMG_W + 32'(col));
      PAT_LFSR:  pixel = WIDTH'(lfsr);
      PAT_CONST: pixel = cfg_const;
      PAT_CHECK: pixel = {WIDTH{row[0] ^ col[0]}};
      default:   pixel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_chip_img_img_update_0_read <= '0;
      read_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      row         <= '0;
      col         <= '0;
      lfsr        <= SEED;
      pat         <= PAT_RAMP;
    end else if (flush) begin
      read_valid <= 1'b0;
      frame_done <= 1'b0;
      row        <= '0;
      col        <= '0;
      lfsr       <= SEED;
    end else if (accept) begin
      off_chip_img_img_update_0_read <= pixel;
      read_valid <= 1'b1;
      pat        <= pat_eff;
      if (pat_eff == PAT_LFSR) begin
        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row         <= '0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end else begin
          row        <= row + RW'(1);
          frame_done <= 1'b0;
        end
      end else begin
        col        <= col + CW'(1);
        frame_done <= 1'b0;
      end
    end else begin
      read_valid <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_off_chip_img_source.sv
// Directed plus randomized bench for off_chip_img_source on a 4x2 image,
// checked against a pixel-index reference model.
module tb_off_chip_img_source;
  localparam int          WIDTH = 16;
  localparam int          IMG_W = 4;
  localparam int          IMG_H = 2;
  localparam int          NPIX  = IMG_W * IMG_H;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       pattern_sel;
  logic [WIDTH-1:0] cfg_const;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic [1:0]       col;
  logic [0:0]       row;
  logic             frame_done;
  logic [15:0]      frame_count;

  off_chip_img_source #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .SEED(SEED)
  ) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .flush                             (flush),
    .pattern_sel                       (pattern_sel),
    .cfg_const                         (cfg_const),
    .off_chip_img_img_update_0_read_en (read_en),
    .off_chip_img_img_update_0_read    (read_data),
    .read_valid                        (read_valid),
    .col                               (col),
    .row                               (row),
    .frame_done                        (frame_done),
    .frame_count                       (frame_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: position kept as a linear pixel index
  int          m_idx;
  int          m_pat;
  logic [15:0] m_lfsr;
  logic [15:0] m_fc;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_done;
  logic [WIDTH-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic model_reset();
    m_idx = 0; m_pat = 0; m_lfsr = SEED; m_fc = 0;
    m_data = 0; m_valid = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic re, input logic fl,
                            input logic [1:0] sel, input logic [15:0] cv);
    int r, c;
    if (fl) begin
      m_idx = 0; m_lfsr = SEED; m_valid = 0; m_done = 0;
    end else if (re) begin
      if (m_idx == 0) m_pat = int'(sel);
      r = m_idx / IMG_W;
      c = m_idx % IMG_W;
      case (m_pat)
        0: m_data = 16'(m_idx);
        1: begin m_data = m_lfsr; m_lfsr = lfsr_next(m_lfsr); end
        2: m_data = cv;
        default: m_data = (((r ^ c) & 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      m_valid = 1;
      m_done  = (m_idx == NPIX - 1);
      if (m_done) m_fc = m_fc + 16'd1;
      m_idx = (m_idx + 1) % NPIX;
      exp_q.push_back(m_data);
    end else begin
      m_valid = 0; m_done = 0;
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] e;
    check("read_valid", 32'(read_valid), 32'(m_valid));
    check("data", 32'(read_data), 32'(m_data));
    check("row", 32'(row), 32'(m_idx / IMG_W));
    check("col", 32'(col), 32'(m_idx % IMG_W));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    if (read_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pixel_stream", 32'(read_data), 32'(e));
    end
  endtask

  // drivers
  task automatic step(input logic re, input logic fl,
                      input logic [1:0] sel, input logic [15:0] cv);
    read_en = re; flush = fl; pattern_sel = sel; cfg_const = cv;
    @(posedge clk);
    model_step(re, fl, sel, cv);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    read_en = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; read_en = 1'b0; pattern_sel = 2'd0; cfg_const = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // ramp with read_en held high: 0..7 then 0, frame_done with 7
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 2'd0, 16'h0);
      if (i == 7) begin
        check("ramp_last", 32'(read_data), 32'd7);
        check("ramp_done", 32'(frame_done), 32'd1);
        check("ramp_fc", 32'(frame_count), 32'd1);
      end
    end

    // toggled requests from the frame origin
    step(1'b0, 1'b1, 2'd0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    step(1'b0, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    step(1'b0, 1'b0, 2'd0, 16'h0);
    check("toggle_hold", 32'(read_data), 32'd2);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    check("toggle_px3", 32'(read_data), 32'd3);

    // LFSR sequence and reseed by flush
    step(1'b0, 1'b1, 2'd1, 16'h0);
    step(1'b1, 1'b0, 2'd1, 16'h0);
    check("lfsr_px0", 32'(read_data), 32'h0000ACE1);
    step(1'b1, 1'b0, 2'd1, 16'h0);
    check("lfsr_px1", 32'(read_data), 32'h00005670);
    step(1'b0, 1'b1, 2'd1, 16'h0);
    step(1'b1, 1'b0, 2'd1, 16'h0);
    check("lfsr_reseed", 32'(read_data), 32'h0000ACE1);

    // pattern switch mid-frame only takes effect at the next frame
    step(1'b0, 1'b1, 2'd0, 16'h00AB);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 16'h00AB);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd2, 16'h00AB);
    check("switch_ramp_end", 32'(read_data), 32'd7);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'd2, 16'h00AB);
    check("switch_const", 32'(read_data), 32'h000000AB);

    // flush colliding with a request at (1,2)
    step(1'b0, 1'b1, 2'd0, 16'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b1, 2'd0, 16'h0);
    check("flush_drop", 32'(read_valid), 32'd0);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    check("flush_origin", 32'(read_data), 32'd0);

    // three frames then a mid-frame asynchronous reset
    async_reset();
    for (int i = 0; i < 3 * NPIX + 3; i++) step(1'b1, 1'b0, 2'd3, 16'h0);
    check("fc_three", 32'(frame_count), 32'd3);
    async_reset();
    step(1'b1, 1'b0, 2'd0, 16'h0);
    check("post_reset_px", 32'(read_data), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           16'($urandom));
      if (i == 200) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/off_chip_img_source.md
# off_chip_img_source

Off-chip image stream source for CGRA app testbenches and power-flow harnesses. It answers an app's `off_chip_img_img_update_0_read_en` requests by returning one pixel per accepted request, one cycle later. Pixels come from a deterministic raster-order pattern generator, so vector runs are reproducible instead of using free-running random data. It tracks the row/column position and frame count, and flags end of frame.

## Interface
Parameters:
- `WIDTH`, 16, pixel width in bits
- `IMG_W`, 64, pixels per row (≥2)
- `IMG_H`, 64, rows per frame (≥1)
- `SEED`, 16'hACE1, LFSR reset/flush value (nonzero)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous restart to frame start
- `pattern_sel`  in  2  0 ramp, 1 LFSR, 2 constant, 3 checkerboard
- `cfg_const`  in  WIDTH  value used by the constant pattern
- `off_chip_img_img_update_0_read_en`  in  1  pixel request from the app
- `off_chip_img_img_update_0_read`  out  WIDTH  returned pixel, registered
- `read_valid`  out  1  high in the cycle the returned pixel is valid
- `col`  out  clog2(IMG_W)  column of the next pixel to issue
- `row`  out  clog2(IMG_H)  row of the next pixel to issue
- `frame_done`  out  1  one-cycle pulse together with the last pixel of a frame
- `frame_count`  out  16  completed frames, wraps at 2^16

## Operation
- A request is accepted in any cycle with `read_en`=1 and `flush`=0.
- An accepted request with pixel position (r,c) produces `read_valid`=1 and the pixel value in the next cycle. Otherwise `read_valid`=0 and the data holds its last value.
- Active pattern register `pat`:
  - Loaded from `pattern_sel` only when a request is accepted at (0,0).
  - A change of `pattern_sel` mid-frame has no effect until the next frame.
  - The pixel at (0,0) itself uses the newly loaded value.
- Patterns:
  - Ramp: (r*IMG_W + c) truncated to WIDTH.
  - LFSR: emit the current state `s`, then advance on the accept: s <= {s[0]^s[2]^s[3]^s[5], s[15:1]}. The LFSR advances only when `pat`=1.
  - Constant: `cfg_const`, sampled in the accept cycle.
  - Checkerboard: all-ones if (r^c)&1 else 0.
- Position counters:
  - `col` increments on each accept.
  - At IMG_W-1, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. That accept sets `frame_done` for the following cycle and increments `frame_count`, visible in the same cycle as `frame_done`.
- `flush`:
  - Clears `row`, `col` and `read_valid` (next cycle), and reloads the LFSR with SEED.
  - Leaves `frame_count` and `pat` unchanged.
  - Takes priority over a simultaneous `read_en`; that request is dropped, not queued.
- No backpressure: the source accepts every request.

## Timing
- Latency: exactly 1 cycle from accepted `read_en` to `read_valid`. Throughput is 1 pixel per cycle.
- Reset values:
  - Data 0, `read_valid` 0, `frame_done` 0, `frame_count` 0.
  - `row`=`col`=0, LFSR=SEED, `pat`=0.
- Asserting `rst_n` low mid-frame clears all state immediately. The first accept after release is pixel (0,0).
- `frame_done` is never high for two consecutive cycles when IMG_W*IMG_H ≥ 2.
- `frame_count` wraps from 16'hFFFF to 0 with no other side effect.

## Test plan
- Ramp, IMG_W=4, IMG_H=2, `read_en` held high after reset: data 0..7, then 0. `frame_done` is high with data 7. `frame_count` goes 0→1 in that cycle.
- Ramp with `read_en` toggled 1,0,1,1,0,1: `read_valid` follows one cycle later; data 0,1,2,3. Idle cycles hold the data and keep `read_valid` 0.
- LFSR, SEED=16'hACE1: first two pixels 16'hACE1, 16'h5670. After `flush`, the next pixel is 16'hACE1 again at `row`=`col`=0.
- `pattern_sel` switched 0→2 (`cfg_const`=16'h00AB) mid-frame: ramp continues to the end of frame. The next frame's pixels are all 16'h00AB.
- `flush` and `read_en` in the same cycle at position (1,2): no `read_valid` next cycle. The next accept returns the pixel for (0,0). `frame_count` is unchanged.
- `rst_n` pulsed low mid-frame with `frame_count`=3: all outputs return to reset values asynchronously. The first pixel after release is ramp value 0.
